// File: rtl/rtx_exec_engine.sv
// rtx_exec_engine: loadable register-transfer program engine, one op per clock
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   prog_we_i/prog_addr_i/prog_data_i  program slot write, instr {op[3:0], dst, src}
//   prog_len_i                     slots to run (0..DEPTH, clamped), sampled at start
//   start_i                        run request, honoured only in IDLE outside the done cycle
//   x_i                            initial register values, slice i loads r[i]
//   busy_o, done_o, y_o            run in progress, one-cycle completion pulse, captured registers
// Build option: define RTX_SAT_ARITH_EN for saturating ADD/SUB/SHL.
module rtx_exec_engine #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int RW = $clog2(NREG),
  localparam int IW = 4 + 2 * RW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  prog_we_i,
  input  logic [AW-1:0]         prog_addr_i,
  input  logic [IW-1:0]         prog_data_i,
  input  logic [AW:0]           prog_len_i,
  input  logic                  start_i,
  input  logic [NREG*WIDTH-1:0] x_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NREG*WIDTH-1:0] y_o
);
  typedef enum logic {IDLE, EXEC} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] r_q [NREG];
  logic [WIDTH-1:0] r_d [NREG];
  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d, len_eff;
  logic [NREG*WIDTH-1:0] y_q, y_d;
  logic done_q, done_d;
  logic [3:0] op;
  logic [RW-1:0] dst, src;
  logic [WIDTH-1:0] a, b, res, add_r, sub_r, shl_r;
  logic go, last;

  assign {op, dst, src} = mem_q[pc_q];
  assign a = r_q[dst];
  assign b = r_q[src];
  assign len_eff = (prog_len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len_i;
  // the done cycle blocks a restart so every completion is seen as a separate pulse
  assign go = (state_q == IDLE) && start_i && !done_q;
  assign last = (op == 4'hF) || ({1'b0, pc_q} == len_q - 1'b1);

`ifdef RTX_SAT_ARITH_EN
  logic [WIDTH:0] sum, diff;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign sub_r = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
  assign shl_r = b[WIDTH-1] ? '1 : b << 1;
`else
  assign add_r = a + b;
  assign sub_r = a - b;
  assign shl_r = b << 1;
`endif

  always_comb begin
    res = a;
    case (op)
      4'd1:    res = b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = {{(WIDTH-1){1'b0}}, b == '0};
      4'd6:    res = ~b;
      4'd7:    res = add_r;
      4'd8:    res = sub_r;
      4'd9:    res = shl_r;
      4'd10:   res = b >> 1;
      default: res = a;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (go && len_eff != '0) state_d = EXEC;
    else if (state_q == EXEC && last) state_d = IDLE;
  end

  always_comb begin
    busy_o = state_q == EXEC;
    done_o = done_q;
    y_o    = y_q;
  end

  // y is captured from the post-op register image so it lands on the same edge as the last op
  always_comb begin
    r_d    = r_q;
    pc_d   = pc_q;
    len_d  = len_q;
    done_d = 1'b0;
    y_d    = y_q;
    if (go) begin
      for (int i = 0; i < NREG; i++) r_d[i] = x_i[i*WIDTH +: WIDTH];
      pc_d   = '0;
      len_d  = len_eff;
      done_d = len_eff == '0;
    end else if (state_q == EXEC) begin
      r_d[dst] = res;
      pc_d     = pc_q + 1'b1;
      done_d   = last;
    end
    if (done_d)
      for (int i = 0; i < NREG; i++) y_d[i*WIDTH +: WIDTH] = r_d[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      pc_q   <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      y_q    <= '0;
    end else begin
      r_q    <= r_d;
      pc_q   <= pc_d;
      len_q  <= len_d;
      done_q <= done_d;
      y_q    <= y_d;
    end

  always_ff @(posedge clk_i)
    if (prog_we_i && state_q != EXEC) mem_q[prog_addr_i] <= prog_data_i;
endmodule

// File: tb/tb_rtx_exec_engine.sv
// tb_rtx_exec_engine: directed checks of rtx_exec_engine (default and 8x8x16 configurations)
module tb_rtx_exec_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  logic we_a = 0, start_a = 0, busy_a, done_a;
  logic [2:0] addr_a = '0;
  logic [7:0] data_a = '0;
  logic [3:0] len_a = '0;
  logic [63:0] x_a = '0, y_a;
  logic we_b = 0, start_b = 0, busy_b, done_b;
  logic [3:0] addr_b = '0;
  logic [9:0] data_b = '0;
  logic [4:0] len_b = '0;
  logic [63:0] x_b = '0, y_b;
  int passed = 0, total = 0, fails = 0;
  int k, nb, nr;
  logic [7:0] rm [8];
  logic [63:0] exp_b;

`ifdef RTX_SAT_ARITH_EN
  localparam logic [15:0] ADD_E = 16'hFFFF, SUB_E = 16'h0000, SHL_E = 16'hFFFF;
`else
  localparam logic [15:0] ADD_E = 16'h0001, SUB_E = 16'hFFFF, SHL_E = 16'h0002;
`endif

  rtx_exec_engine dut_a (
    .clk_i(clk), .rst_ni(rst_n), .prog_we_i(we_a), .prog_addr_i(addr_a),
    .prog_data_i(data_a), .prog_len_i(len_a), .start_i(start_a), .x_i(x_a),
    .busy_o(busy_a), .done_o(done_a), .y_o(y_a));

  rtx_exec_engine #(.WIDTH(8), .NREG(8), .DEPTH(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .prog_we_i(we_b), .prog_addr_i(addr_b),
    .prog_data_i(data_b), .prog_len_i(len_b), .start_i(start_b), .x_i(x_b),
    .busy_o(busy_b), .done_o(done_b), .y_o(y_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ia(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s);
    return {op, d, s};
  endfunction

  task automatic load_a(input logic [2:0] ad, input logic [7:0] dt);
    we_a = 1; addr_a = ad; data_a = dt;
    @(negedge clk);
    we_a = 0;
  endtask

  task automatic load_b(input logic [3:0] ad, input logic [9:0] dt);
    we_b = 1; addr_b = ad; data_b = dt;
    @(negedge clk);
    we_b = 0;
  endtask

  // hold keeps start high until done and drives a HALT write to slot 0 while busy
  task automatic go_a(input logic [3:0] len, input logic [63:0] xv, input bit hold,
                      output int kk, output int bb);
    x_a = xv; len_a = len; start_a = 1; kk = 0; bb = 0;
    do begin
      @(negedge clk);
      kk++;
      if (!hold) start_a = 0;
      else if (kk == 1) begin we_a = 1; addr_a = 3'd0; data_a = 8'hF0; end
      if (busy_a) bb++;
    end while (!done_a && kk < 40);
    start_a = 0; we_a = 0;
  endtask

  task automatic go_b(input logic [4:0] len, input logic [63:0] xv, output int kk, output int bb);
    x_b = xv; len_b = len; start_b = 1; kk = 0; bb = 0;
    do begin
      @(negedge clk);
      kk++;
      start_b = 0;
      if (busy_b) bb++;
    end while (!done_b && kk < 60);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_y", y_a, 64'd0);
    rst_n = 1;
    @(negedge clk);

    load_a(0, ia(2, 0, 3)); load_a(1, ia(5, 1, 0));
    load_a(2, ia(5, 3, 3)); load_a(3, ia(2, 0, 1));
    go_a(4, {16'h0FF0, 16'hBEEF, 16'h1234, 16'h00F0}, 0, k, nb);
    chk("evo_lat", 64'(k), 64'd5);
    chk("evo_busy", 64'(nb), 64'd4);
    chk("evo_y", y_a, {16'h0000, 16'hBEEF, 16'h0000, 16'h0000});
    @(negedge clk);
    chk("evo_pulse", 64'(done_a), 64'd0);

    load_a(0, ia(1, 2, 0)); load_a(1, 8'hF0);
    go_a(8, {16'h0FF0, 16'hBEEF, 16'h1234, 16'h00F0}, 0, k, nb);
    chk("halt_lat", 64'(k), 64'd3);
    chk("halt_busy", 64'(nb), 64'd2);
    chk("halt_y", y_a, {16'h0FF0, 16'h00F0, 16'h1234, 16'h00F0});
    @(negedge clk);

    go_a(0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, k, nb);
    chk("len0_lat", 64'(k), 64'd1);
    chk("len0_busy", 64'(nb), 64'd0);
    chk("len0_y", y_a, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    @(negedge clk);

    load_a(0, ia(3, 2, 0)); load_a(1, ia(4, 2, 1)); load_a(2, ia(6, 0, 2));
    load_a(3, ia(10, 1, 3)); load_a(4, ia(8, 3, 1)); load_a(5, ia(7, 1, 1));
    load_a(6, ia(0, 2, 2)); load_a(7, ia(12, 0, 0));
    go_a(8, {16'h8001, 16'h0000, 16'h0F0F, 16'h00F0}, 0, k, nb);
    chk("alu_lat", 64'(k), 64'd9);
    chk("alu_busy", 64'(nb), 64'd8);
    chk("alu_y", y_a, {16'h4001, 16'h0FFF, 16'h8000, 16'hF000});
    @(negedge clk);

    load_a(0, ia(7, 0, 1)); load_a(1, ia(8, 2, 3)); load_a(2, 8'hF0);
    go_a(8, {16'h0003, 16'h0002, 16'h0002, 16'hFFFF}, 0, k, nb);
    chk("arith_lat", 64'(k), 64'd4);
    chk("arith_y", y_a, {16'h0003, SUB_E, 16'h0002, ADD_E});
    @(negedge clk);

    load_a(0, ia(9, 1, 0)); load_a(1, ia(9, 2, 2));
    go_a(2, {16'h0000, 16'h4001, 16'h0000, 16'h8001}, 0, k, nb);
    chk("shl_lat", 64'(k), 64'd3);
    chk("shl_y", y_a, {16'h0000, 16'h8002, SHL_E, 16'h8001});
    @(negedge clk);

    load_a(0, ia(1, 1, 0)); load_a(1, ia(7, 1, 1));
    load_a(2, ia(1, 2, 1)); load_a(3, ia(4, 3, 2));
    go_a(4, {16'h0100, 16'h0000, 16'h0000, 16'h0011}, 1, k, nb);
    chk("hold_lat", 64'(k), 64'd5);
    chk("hold_busy", 64'(nb), 64'd4);
    chk("hold_y", y_a, {16'h0122, 16'h0022, 16'h0022, 16'h0011});
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nr += int'(busy_a) + int'(done_a);
    end
    chk("hold_norestart", 64'(nr), 64'd0);
    go_a(4, {16'h0000, 16'h0000, 16'h0000, 16'h0003}, 0, k, nb);
    chk("hold_prog_lat", 64'(k), 64'd5);
    chk("hold_prog_y", y_a, {16'h0006, 16'h0006, 16'h0006, 16'h0003});
    @(negedge clk);

    x_a = {16'h0000, 16'h0000, 16'h0000, 16'h0005}; len_a = 4; start_a = 1;
    @(negedge clk);
    start_a = 0;
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_done", 64'(done_a), 64'd0);
    chk("arst_y", y_a, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go_a(4, {16'h0000, 16'h0000, 16'h0000, 16'h0005}, 0, k, nb);
    chk("arst_rerun_lat", 64'(k), 64'd5);
    chk("arst_rerun_y", y_a, {16'h000A, 16'h000A, 16'h000A, 16'h0005});
    @(negedge clk);

    x_b = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) rm[i] = x_b[i*8 +: 8];
    for (int i = 0; i < 16; i++) begin
      logic [2:0] d, s;
      d = 3'((i * 3 + 1) % 8);
      s = 3'((i * 5 + 2) % 8);
      load_b(4'(i), {(i % 2 == 1) ? 4'd4 : 4'd1, d, s});
      rm[d] = (i % 2 == 1) ? (rm[d] ^ rm[s]) : rm[s];
    end
    for (int i = 0; i < 8; i++) exp_b[i*8 +: 8] = rm[i];
    go_b(5'd20, x_b, k, nb);
    chk("sweep_lat", 64'(k), 64'd17);
    chk("sweep_busy", 64'(nb), 64'd16);
    chk("sweep_y", y_b, exp_b);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
